// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the multi-step universal shift register:
//   - default register width and shift-amount field width
//   - command opcode encodings (OP_HOLD .. OP_CLR)
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - helper that tells multi-step shift/rotate opcodes apart from the
//     single-cycle ones
// ---------------------------------------------------------------------------
package usr_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_AMT_W = 4;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_SHR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_ASR  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // True for the opcodes that walk the register one bit per cycle.
   function automatic logic isShiftOp(input logic [2:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
             (op == OP_ROR) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/usr_step_unit.sv
// ---------------------------------------------------------------------------
// usr_step_unit
// Purely combinational single-step function: given the current register
// value and the latched opcode, produce the value after one shift/rotate
// step. Non-shift opcodes pass the register through unchanged.
//
// Ports:
//   i_op     in  3      latched opcode
//   i_q      in  WIDTH  current register contents
//   i_serInL in  1      fill bit entering bit 0 on SHL
//   i_serInR in  1      fill bit entering bit WIDTH-1 on SHR
//   o_next   out WIDTH  register value after one step
// ---------------------------------------------------------------------------
module usr_step_unit
   import usr_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_serInL,
   input  logic             i_serInR,
   output logic [WIDTH-1:0] o_next
);

   // One step of each shift flavour; ASR replicates the sign bit so that
   // long arithmetic shifts settle at all-sign.
   always_comb begin
      o_next = i_q;
      case (i_op)
         OP_SHL:  o_next = {i_q[WIDTH-2:0], i_serInL};
         OP_SHR:  o_next = {i_serInR, i_q[WIDTH-1:1]};
         OP_ROL:  o_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
         OP_ROR:  o_next = {i_q[0], i_q[WIDTH-1:1]};
         OP_ASR:  o_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
         default: o_next = i_q;
      endcase
   end

endmodule

// File: rtl/usr_seq_shifter.sv
// ---------------------------------------------------------------------------
// usr_seq_shifter
// Multi-step universal shift register with a valid/ready command handshake.
// Single-cycle commands (HOLD, LOAD, CLR, zero-amount shifts) go straight to
// DONE; shift/rotate commands walk one bit per cycle in SHIFT for cmd_amt
// cycles, then pass through DONE, which pulses done for one cycle.
//
// Ports:
//   clk        in  1      clock, posedge
//   rst        in  1      synchronous active-high reset
//   cmd_valid  in  1      command present
//   cmd_ready  out 1      command can be accepted (IDLE only)
//   cmd_op     in  3      opcode (see usr_pkg)
//   cmd_amt    in  AMT_W  step count for shift/rotate opcodes
//   load_data  in  WIDTH  parallel load value
//   ser_in_l   in  1      SHL fill bit, sampled on every step
//   ser_in_r   in  1      SHR fill bit, sampled on every step
//   q          out WIDTH  registered contents
//   ser_out_l  out 1      q[WIDTH-1]
//   ser_out_r  out 1      q[0]
//   busy       out 1      high in SHIFT and DONE
//   done       out 1      one-cycle completion pulse
// ---------------------------------------------------------------------------
module usr_seq_shifter
   import usr_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int AMT_W = DEFAULT_AMT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ser_in_l,
   input  logic             ser_in_r,
   output logic [WIDTH-1:0] q,
   output logic             ser_out_l,
   output logic             ser_out_r,
   output logic             busy,
   output logic             done
);

   state_t             r_state;
   logic [AMT_W-1:0]   r_cnt;
   logic [2:0]         r_op;
   logic [WIDTH-1:0]   r_q;

   state_t             w_stateNext;
   logic [AMT_W-1:0]   w_cntNext;
   logic [2:0]         w_opNext;
   logic [WIDTH-1:0]   w_qNext;
   logic [WIDTH-1:0]   w_stepQ;

   usr_step_unit #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_op     (r_op),
      .i_q      (r_q),
      .i_serInL (ser_in_l),
      .i_serInR (ser_in_r),
      .o_next   (w_stepQ)
   );

   // Next-state logic. Every command outcome that does not need stepping
   // (HOLD, LOAD, CLR, shift with zero amount) lands in DONE directly, so
   // done always trails the accept edge by exactly one cycle for those.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_opNext    = r_op;
      w_qNext     = r_q;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_stateNext = ST_DONE;
               if (cmd_op == OP_LOAD) begin
                  w_qNext = load_data;
               end else if (cmd_op == OP_CLR) begin
                  w_qNext = '0;
               end else if (isShiftOp(cmd_op) && (cmd_amt != '0)) begin
                  w_opNext    = cmd_op;
                  w_cntNext   = cmd_amt;
                  w_stateNext = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            w_qNext   = w_stepQ;
            w_cntNext = r_cnt - AMT_W'(1);
            if (r_cnt == AMT_W'(1)) begin
               w_stateNext = ST_DONE;
            end
         end
         ST_DONE: begin
            w_stateNext = ST_IDLE;
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // State, counter, latched opcode and data register. Reset wins over an
   // in-flight shift, which is simply abandoned without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_op    <= OP_HOLD;
         r_q     <= '0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
         r_op    <= w_opNext;
         r_q     <= w_qNext;
      end
   end

   // Status decode straight from the state register.
   always_comb begin
      cmd_ready = (r_state == ST_IDLE);
      busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
      done      = (r_state == ST_DONE);
      q         = r_q;
      ser_out_l = r_q[WIDTH-1];
      ser_out_r = r_q[0];
   end

endmodule

// File: tb/tb_usr_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_usr_seq_shifter
// Directed bench for usr_seq_shifter (WIDTH=8, AMT_W=4) with hand-computed
// expected values.
// ---------------------------------------------------------------------------
module tb_usr_seq_shifter;
   import usr_pkg::*;

   localparam int WIDTH = 8;
   localparam int AMT_W = 4;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [AMT_W-1:0] cmd_amt;
   logic [WIDTH-1:0] load_data;
   logic             ser_in_l;
   logic             ser_in_r;
   logic [WIDTH-1:0] q;
   logic             ser_out_l;
   logic             ser_out_r;
   logic             busy;
   logic             done;

   int nChecks = 0;
   int nPassed = 0;

   usr_seq_shifter #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_amt   (cmd_amt),
      .load_data (load_data),
      .ser_in_l  (ser_in_l),
      .ser_in_r  (ser_in_r),
      .q         (q),
      .ser_out_l (ser_out_l),
      .ser_out_r (ser_out_r),
      .busy      (busy),
      .done      (done)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and tally it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nChecks++;
      if (observed === expected) begin
         nPassed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command, wait (bounded) for cmd_ready, let it be accepted,
   // then withdraw it. Returns one step after the accept edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [AMT_W-1:0] amt,
                                input logic [WIDTH-1:0] data);
      int waitCycles;
      cmd_op    = op;
      cmd_amt   = amt;
      load_data = data;
      cmd_valid = 1'b1;
      waitCycles = 0;
      while (!cmd_ready && waitCycles < 40) begin
         tick();
         waitCycles++;
      end
      if (!cmd_ready) checkOutput("ready_timeout", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin : stimulus
      logic [7:0] rolExp [3];
      logic       shlFill [4];
      logic [7:0] shlExp [4];
      int         busyCount;

      rolExp  = '{8'h03, 8'h06, 8'h0C};
      shlFill = '{1'b1, 1'b0, 1'b1, 1'b1};
      shlExp  = '{8'h01, 8'h02, 8'h05, 8'h0B};

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_HOLD;
      cmd_amt   = '0;
      load_data = '0;
      ser_in_l  = 1'b0;
      ser_in_r  = 1'b0;

      // Reset state
      tick();
      tick();
      checkOutput("rst_q", 32'(q), 32'h00);
      checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();

      // LOAD 0xA5: done one cycle after accept, lasts one cycle
      applyStimulus(OP_LOAD, 4'd0, 8'hA5);
      checkOutput("load_q", 32'(q), 32'hA5);
      checkOutput("load_done", 32'(done), 32'd1);
      checkOutput("load_ready_low", 32'(cmd_ready), 32'd0);
      tick();
      checkOutput("load_done_off", 32'(done), 32'd0);
      checkOutput("load_ready_back", 32'(cmd_ready), 32'd1);

      // LOAD 0x81 then ROL by 3
      applyStimulus(OP_LOAD, 4'd0, 8'h81);
      tick();
      applyStimulus(OP_ROL, 4'd3, 8'h00);
      busyCount = 0;
      checkOutput("rol_q_hold", 32'(q), 32'h81);
      if (busy) busyCount++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (busy) busyCount++;
         checkOutput($sformatf("rol_step%0d", i + 1), 32'(q), 32'(rolExp[i]));
         checkOutput($sformatf("rol_done%0d", i + 1), 32'(done), (i == 2) ? 32'd1 : 32'd0);
      end
      tick();
      if (busy) busyCount++;
      checkOutput("rol_busy_cycles", 32'(busyCount), 32'd4);
      checkOutput("rol_idle_ready", 32'(cmd_ready), 32'd1);

      // LOAD 0x80 then ASR by 10: saturates after 7 steps
      applyStimulus(OP_LOAD, 4'd0, 8'h80);
      tick();
      applyStimulus(OP_ASR, 4'd10, 8'h00);
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 1) checkOutput("asr_step1", 32'(q), 32'hC0);
         if (i == 7) checkOutput("asr_step7", 32'(q), 32'hFF);
         if (i == 9) checkOutput("asr_done_early", 32'(done), 32'd0);
         if (i == 10) begin
            checkOutput("asr_final", 32'(q), 32'hFF);
            checkOutput("asr_done", 32'(done), 32'd1);
         end
      end
      tick();

      // LOAD 0x00 then SHL by 4 with live fill 1,0,1,1
      applyStimulus(OP_LOAD, 4'd0, 8'h00);
      tick();
      applyStimulus(OP_SHL, 4'd4, 8'h00);
      for (int i = 0; i < 4; i++) begin
         ser_in_l = shlFill[i];
         tick();
         checkOutput($sformatf("shl_ser_out_r%0d", i + 1), 32'(ser_out_r), 32'(shlExp[i][0]));
      end
      ser_in_l = 1'b0;
      checkOutput("shl_final", 32'(q), 32'h0B);
      checkOutput("shl_ser_out_l", 32'(ser_out_l), 32'd0);
      checkOutput("shl_done", 32'(done), 32'd1);
      tick();

      // SHR by 5 from 0xF0 with fill 1, reset in the 3rd SHIFT cycle
      applyStimulus(OP_LOAD, 4'd0, 8'hF0);
      tick();
      ser_in_r = 1'b1;
      applyStimulus(OP_SHR, 4'd5, 8'h00);
      cmd_valid = 1'b1;
      cmd_op    = OP_LOAD;
      load_data = 8'h55;
      checkOutput("shr_ready_c1", 32'(cmd_ready), 32'd0);
      tick();
      checkOutput("shr_step1", 32'(q), 32'hF8);
      checkOutput("shr_ready_c2", 32'(cmd_ready), 32'd0);
      tick();
      checkOutput("shr_step2", 32'(q), 32'hFC);
      cmd_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ser_in_r = 1'b0;
      checkOutput("shr_rst_q", 32'(q), 32'h00);
      checkOutput("shr_rst_ready", 32'(cmd_ready), 32'd1);
      checkOutput("shr_rst_busy", 32'(busy), 32'd0);
      checkOutput("shr_rst_done", 32'(done), 32'd0);
      tick();
      checkOutput("shr_no_done", 32'(done), 32'd0);
      checkOutput("shr_q_idle", 32'(q), 32'h00);

      // ROR by 0 and HOLD on 0x3C; command during DONE waits for IDLE
      applyStimulus(OP_LOAD, 4'd0, 8'h3C);
      tick();
      applyStimulus(OP_ROR, 4'd0, 8'h00);
      checkOutput("ror0_q", 32'(q), 32'h3C);
      checkOutput("ror0_done", 32'(done), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = OP_LOAD;
      load_data = 8'hFF;
      tick();
      checkOutput("ror0_not_accepted_q", 32'(q), 32'h3C);
      checkOutput("ror0_idle_ready", 32'(cmd_ready), 32'd1);
      checkOutput("ror0_done_off", 32'(done), 32'd0);
      cmd_valid = 1'b0;
      applyStimulus(OP_HOLD, 4'd7, 8'hFF);
      checkOutput("hold_q", 32'(q), 32'h3C);
      checkOutput("hold_done", 32'(done), 32'd1);
      tick();
      checkOutput("hold_done_off", 32'(done), 32'd0);

      // CLR
      applyStimulus(OP_CLR, 4'd0, 8'hFF);
      checkOutput("clr_q", 32'(q), 32'h00);
      checkOutput("clr_done", 32'(done), 32'd1);
      tick();

      $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

   // Hard stop so the run can never hang.
   initial begin : watchdog
      #50000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

endmodule
